// File: rtl/mem_line_requester_if.sv
// ---------------------------------------------------------------------------
// mem_line_requester_if
//
// Bundles the signals around the line-miss initiator:
//   miss_*      cache controller -> requester (miss request, victim writeback)
//   miss_ready  requester -> cache controller (idle, can take a miss)
//   fill_*      requester -> cache controller (one-cycle fill result)
//   mem_*       requester -> memory line port (read/write request)
//   mem_resp_*  memory line port -> requester (response)
//
// Modports:
//   master  the requester block itself
//   slave   its environment (cache controller plus memory line port)
// ---------------------------------------------------------------------------
interface mem_line_requester_if #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 10
);
    logic                  miss_valid;
    logic                  miss_ready;
    logic [ADDR_WIDTH-1:0] miss_line_addr;
    logic                  miss_wb_en;
    logic [ADDR_WIDTH-1:0] miss_wb_addr;
    logic [LINE_WIDTH-1:0] miss_wb_data;

    logic                  fill_valid;
    logic [ADDR_WIDTH-1:0] fill_line_addr;
    logic [LINE_WIDTH-1:0] fill_data;
    logic                  fill_uninit;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_line_addr;
    logic [LINE_WIDTH-1:0] mem_line_data;
    logic                  mem_resp_valid;
    logic [LINE_WIDTH-1:0] mem_resp_line_data;

    modport master (
        input  miss_valid, miss_line_addr, miss_wb_en, miss_wb_addr, miss_wb_data,
        input  mem_resp_valid, mem_resp_line_data,
        output miss_ready,
        output fill_valid, fill_line_addr, fill_data, fill_uninit,
        output mem_read, mem_write, mem_line_addr, mem_line_data
    );

    modport slave (
        output miss_valid, miss_line_addr, miss_wb_en, miss_wb_addr, miss_wb_data,
        output mem_resp_valid, mem_resp_line_data,
        input  miss_ready,
        input  fill_valid, fill_line_addr, fill_data, fill_uninit,
        input  mem_read, mem_write, mem_line_addr, mem_line_data
    );
endinterface

// File: rtl/mem_line_requester.sv
// ---------------------------------------------------------------------------
// mem_line_requester
//
// Line-miss initiator between the L1 cache controller and the memory line
// port. Takes one miss at a time, optionally writes back the dirty victim,
// issues the line read, waits RESP_LATENCY cycles, samples the response and
// returns a one-cycle fill pulse to the cache.
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   bus    mem_line_requester_if.master: miss request/ready, fill result,
//          memory request (read/write/addr/data) and memory response
//
// Every output is a flop. Each output's next value is computed together with
// the next state, so the outputs line up with the state they belong to
// (e.g. mem_write is high exactly while the FSM sits in WB).
// ---------------------------------------------------------------------------
module mem_line_requester #(
    parameter int LINE_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 10,
    parameter int RESP_LATENCY = 1     // legal values >= 1
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_line_requester_if.master bus
);

    localparam int CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RD,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] line_addr_q;
    logic                  latch_en;

    logic                  miss_ready_q,     miss_ready_d;
    logic                  fill_valid_q,     fill_valid_d;
    logic [ADDR_WIDTH-1:0] fill_line_addr_q, fill_line_addr_d;
    logic [LINE_WIDTH-1:0] fill_data_q,      fill_data_d;
    logic                  fill_uninit_q,    fill_uninit_d;
    logic                  mem_read_q,       mem_read_d;
    logic                  mem_write_q,      mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_line_addr_q,  mem_line_addr_d;
    logic [LINE_WIDTH-1:0] mem_line_data_q,  mem_line_data_d;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d          = state_q;
        cnt_d            = cnt_q;
        latch_en         = 1'b0;
        miss_ready_d     = 1'b0;
        fill_valid_d     = 1'b0;
        fill_line_addr_d = fill_line_addr_q;
        fill_data_d      = fill_data_q;
        fill_uninit_d    = fill_uninit_q;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        mem_line_addr_d  = mem_line_addr_q;
        mem_line_data_d  = mem_line_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.miss_valid) begin
                    latch_en = 1'b1;
                    // The victim address/data go straight into the request
                    // registers, which then serve as the writeback latch.
                    if (bus.miss_wb_en) begin
                        state_d         = ST_WB;
                        mem_write_d     = 1'b1;
                        mem_line_addr_d = bus.miss_wb_addr;
                        mem_line_data_d = bus.miss_wb_data;
                    end else begin
                        state_d         = ST_RD;
                        mem_read_d      = 1'b1;
                        mem_line_addr_d = bus.miss_line_addr;
                    end
                end else begin
                    miss_ready_d = 1'b1;
                end
            end

            ST_WB: begin
                state_d         = ST_RD;
                mem_read_d      = 1'b1;
                mem_line_addr_d = line_addr_q;
            end

            ST_RD: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(RESP_LATENCY - 1);
            end

            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d          = ST_DONE;
                    fill_valid_d     = 1'b1;
                    fill_line_addr_d = line_addr_q;
                    fill_data_d      = bus.mem_resp_valid ? bus.mem_resp_line_data : '0;
                    fill_uninit_d    = ~bus.mem_resp_valid;
                end
            end

            ST_DONE: begin
                state_d      = ST_IDLE;
                miss_ready_d = 1'b1;
            end

            default: begin
                state_d      = ST_IDLE;
                miss_ready_d = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            miss_ready_q     <= 1'b1;
            fill_valid_q     <= 1'b0;
            fill_line_addr_q <= '0;
            fill_data_q      <= '0;
            fill_uninit_q    <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_line_addr_q  <= '0;
            mem_line_data_q  <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            miss_ready_q     <= miss_ready_d;
            fill_valid_q     <= fill_valid_d;
            fill_line_addr_q <= fill_line_addr_d;
            fill_data_q      <= fill_data_d;
            fill_uninit_q    <= fill_uninit_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_line_addr_q  <= mem_line_addr_d;
            mem_line_data_q  <= mem_line_data_d;
        end
    end

    // NOTE: the latched miss address is pure datapath; it is only consumed in
    // states reached after a fresh load, so it carries no reset.
    always_ff @(posedge clock) begin
        if (latch_en) begin
            line_addr_q <= bus.miss_line_addr;
        end
    end

    assign bus.miss_ready     = miss_ready_q;
    assign bus.fill_valid     = fill_valid_q;
    assign bus.fill_line_addr = fill_line_addr_q;
    assign bus.fill_data      = fill_data_q;
    assign bus.fill_uninit    = fill_uninit_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_line_addr  = mem_line_addr_q;
    assign bus.mem_line_data  = mem_line_data_q;

endmodule

// File: tb/tb_mem_line_requester.sv
// ---------------------------------------------------------------------------
// tb_mem_line_requester
//
// Two requesters share one clock: instance 0 with RESP_LATENCY=1 and
// instance 1 with RESP_LATENCY=3. Each has a memory device model (line array
// plus valid bits, response presented only in the cycle it is due, junk
// otherwise) and a reference model that predicts every output from the miss
// timeline: a miss accepted at edge p occupies 2+L (no writeback) or 3+L
// (writeback) cycles, with write at offset 0, read at offset 0/1 and the
// fill pulse in the last busy cycle.
// ---------------------------------------------------------------------------
module tb_mem_line_requester;

    localparam int LW   = 128;
    localparam int AW   = 10;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] rst_n;

    // stimulus towards the cache side of each instance
    logic [1:0]         mv, we;
    logic [1:0][AW-1:0] la, wa;
    logic [1:0][LW-1:0] wd;

    // memory responses driven by the device model
    logic [1:0]         rv;
    logic [1:0][LW-1:0] rdat;

    // observed outputs
    logic [1:0]         o_rdy, o_fv, o_fu, o_rd, o_wr;
    logic [1:0][AW-1:0] o_fa, o_ma;
    logic [1:0][LW-1:0] o_fd, o_md;

    mem_line_requester_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus0 ();
    mem_line_requester_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus1 ();

    mem_line_requester #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RESP_LATENCY(LAT0)) dut0 (
        .clock (clock),
        .reset (rst_n[0]),
        .bus   (bus0)
    );

    mem_line_requester #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RESP_LATENCY(LAT1)) dut1 (
        .clock (clock),
        .reset (rst_n[1]),
        .bus   (bus1)
    );

    assign bus0.miss_valid         = mv[0];
    assign bus0.miss_line_addr     = la[0];
    assign bus0.miss_wb_en         = we[0];
    assign bus0.miss_wb_addr       = wa[0];
    assign bus0.miss_wb_data       = wd[0];
    assign bus0.mem_resp_valid     = rv[0];
    assign bus0.mem_resp_line_data = rdat[0];
    assign bus1.miss_valid         = mv[1];
    assign bus1.miss_line_addr     = la[1];
    assign bus1.miss_wb_en         = we[1];
    assign bus1.miss_wb_addr       = wa[1];
    assign bus1.miss_wb_data       = wd[1];
    assign bus1.mem_resp_valid     = rv[1];
    assign bus1.mem_resp_line_data = rdat[1];

    assign o_rdy = {bus1.miss_ready,     bus0.miss_ready};
    assign o_fv  = {bus1.fill_valid,     bus0.fill_valid};
    assign o_fu  = {bus1.fill_uninit,    bus0.fill_uninit};
    assign o_rd  = {bus1.mem_read,       bus0.mem_read};
    assign o_wr  = {bus1.mem_write,      bus0.mem_write};
    assign o_fa  = {bus1.fill_line_addr, bus0.fill_line_addr};
    assign o_ma  = {bus1.mem_line_addr,  bus0.mem_line_addr};
    assign o_fd  = {bus1.fill_data,      bus0.fill_data};
    assign o_md  = {bus1.mem_line_data,  bus0.mem_line_data};

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // -----------------------------------------------------------------------
    // Memory device model
    // -----------------------------------------------------------------------
    bit [LW-1:0] dev_mem [2][1024];
    bit          dev_val [2][1024];
    bit          pend    [2];
    int          pcnt    [2];
    bit          pv      [2];
    bit [LW-1:0] pd      [2];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (o_wr[k]) begin
                dev_mem[k][o_ma[k]] = o_md[k];
                dev_val[k][o_ma[k]] = 1'b1;
            end
            if (o_rd[k]) begin
                pend[k] = 1'b1;
                pcnt[k] = lat_of(k) - 1;
                pv[k]   = dev_val[k][o_ma[k]];
                pd[k]   = dev_mem[k][o_ma[k]];
            end else if (pend[k] && pcnt[k] > 0) begin
                pcnt[k]--;
            end else begin
                pend[k] = 1'b0;
            end
            if (pend[k] && pcnt[k] == 0) begin
                rv[k]   <= pv[k];
                rdat[k] <= pv[k] ? pd[k] : {$urandom, $urandom, $urandom, $urandom};
            end else begin
                rv[k]   <= 1'($urandom);
                rdat[k] <= {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reference model: one accepted miss = a fixed-length timeline
    // -----------------------------------------------------------------------
    bit [LW-1:0] ref_mem [2][1024];
    bit          ref_val [2][1024];
    bit          m_busy  [2];
    bit          m_wb    [2];
    int          m_d     [2];
    int          m_len   [2];
    bit [AW-1:0] e_ra [2], e_wa [2], e_fa [2], f_a [2];
    bit [LW-1:0] e_wd [2], e_fd [2], f_d [2];
    bit          e_fu [2], f_u [2];

    task automatic model_reset(input int k);
        m_busy[k] = 1'b0;
        m_d[k]    = 0;
        e_fa[k]   = '0;
        e_fd[k]   = '0;
        e_fu[k]   = 1'b0;
    endtask

    task automatic model_tick(input int k);
        if (m_busy[k]) begin
            m_d[k]++;
            if (m_d[k] == m_len[k]) m_busy[k] = 1'b0;
        end else if (mv[k]) begin
            m_busy[k] = 1'b1;
            m_d[k]    = 0;
            m_wb[k]   = we[k];
            m_len[k]  = (we[k] ? 3 : 2) + lat_of(k);
            if (we[k]) begin
                ref_mem[k][wa[k]] = wd[k];
                ref_val[k][wa[k]] = 1'b1;
                e_wa[k] = wa[k];
                e_wd[k] = wd[k];
            end
            e_ra[k] = la[k];
            f_a[k]  = la[k];
            f_u[k]  = !ref_val[k][la[k]];
            f_d[k]  = ref_val[k][la[k]] ? ref_mem[k][la[k]] : '0;
        end
        if (m_busy[k] && m_d[k] == m_len[k] - 1) begin
            e_fa[k] = f_a[k];
            e_fd[k] = f_d[k];
            e_fu[k] = f_u[k];
        end
    endtask

    always @(posedge clock or negedge rst_n[0]) begin
        if (!rst_n[0]) model_reset(0);
        else           model_tick(0);
    end

    always @(posedge clock or negedge rst_n[1]) begin
        if (!rst_n[1]) model_reset(1);
        else           model_tick(1);
    end

    // -----------------------------------------------------------------------
    // Per-cycle compare against the model
    // -----------------------------------------------------------------------
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic e_wr, e_rd, e_fv;
                e_wr = m_busy[k] && m_wb[k] && m_d[k] == 0;
                e_rd = m_busy[k] && m_d[k] == (m_wb[k] ? 1 : 0);
                e_fv = m_busy[k] && m_d[k] == m_len[k] - 1;
                check($sformatf("miss_ready[%0d]", k),     LW'(o_rdy[k]), LW'(!m_busy[k]));
                check($sformatf("mem_write[%0d]", k),      LW'(o_wr[k]),  LW'(e_wr));
                check($sformatf("mem_read[%0d]", k),       LW'(o_rd[k]),  LW'(e_rd));
                check($sformatf("rw_overlap[%0d]", k),     LW'(o_rd[k] & o_wr[k]), '0);
                check($sformatf("fill_valid[%0d]", k),     LW'(o_fv[k]),  LW'(e_fv));
                check($sformatf("fill_line_addr[%0d]", k), LW'(o_fa[k]),  LW'(e_fa[k]));
                check($sformatf("fill_data[%0d]", k),      o_fd[k],       e_fd[k]);
                check($sformatf("fill_uninit[%0d]", k),    LW'(o_fu[k]),  LW'(e_fu[k]));
                if (e_wr) begin
                    check($sformatf("wb_addr[%0d]", k), LW'(o_ma[k]), LW'(e_wa[k]));
                    check($sformatf("wb_data[%0d]", k), o_md[k],      e_wd[k]);
                end
                if (e_rd) begin
                    check($sformatf("rd_addr[%0d]", k), LW'(o_ma[k]), LW'(e_ra[k]));
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic run_miss(input int k, input logic [AW-1:0] l, input logic w,
                            input logic [AW-1:0] a, input logic [LW-1:0] d,
                            output int lat_c, output int n_rd, output int n_wr,
                            output logic [AW-1:0] rd_a, output logic [AW-1:0] wr_a,
                            output logic [LW-1:0] wr_d);
        int guard = 0;
        @(negedge clock);
        while (!o_rdy[k] && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("ready_before_miss", LW'(o_rdy[k]), LW'(1));
        mv[k] = 1'b1; la[k] = l; we[k] = w; wa[k] = a; wd[k] = d;
        lat_c = 0; n_rd = 0; n_wr = 0; rd_a = '0; wr_a = '0; wr_d = '0;
        do begin
            @(negedge clock);
            lat_c++;
            if (lat_c == 1) mv[k] = 1'b0;
            if (o_rd[k]) begin n_rd++; rd_a = o_ma[k]; end
            if (o_wr[k]) begin n_wr++; wr_a = o_ma[k]; wr_d = o_md[k]; end
        end while (!o_fv[k] && lat_c < 20);
        check("fill_seen", LW'(o_fv[k]), LW'(1));
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r = $urandom_range(0, 8);
        return (r == 8) ? {AW{1'b1}} : AW'(r);
    endfunction

    task automatic rand_run(input int k);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            mv[k] = 1'($urandom_range(0, 1));
            la[k] = pick_addr();
            we[k] = 1'($urandom_range(0, 1));
            wa[k] = ($urandom_range(0, 3) == 0) ? la[k] : pick_addr();
            wd[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clock);
        mv[k] = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        int lat_c, n_rd, n_wr;
        logic [AW-1:0] rd_a, wr_a;
        logic [LW-1:0] wr_d;
        int rd_cyc[$];

        rst_n = 2'b00; mv = '0; we = '0; la = '0; wa = '0; wd = '0;
        @(negedge clock);
        chk_en = 1'b1;
        check("rst_miss_ready", LW'(o_rdy[0]), LW'(1));
        check("rst_fill_valid", LW'(o_fv[0]), '0);
        check("rst_mem_rw",     LW'({o_rd[0], o_wr[0]}), '0);
        check("rst_fill_data",  o_fd[0], '0);
        @(negedge clock);
        rst_n = 2'b11;

        // 1: plain miss into fresh memory
        run_miss(0, 10'h005, 1'b0, '0, '0, lat_c, n_rd, n_wr, rd_a, wr_a, wr_d);
        check("t1_latency", LW'(lat_c), LW'(3));
        check("t1_reads",   LW'(n_rd),  LW'(1));
        check("t1_writes",  LW'(n_wr),  LW'(0));
        check("t1_rd_addr", LW'(rd_a),  LW'(10'h005));
        check("t1_uninit",  LW'(o_fu[0]), LW'(1));
        check("t1_data",    o_fd[0], '0);

        // 2: writeback then read of the same line
        run_miss(0, 10'h010, 1'b1, 10'h010, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF,
                 lat_c, n_rd, n_wr, rd_a, wr_a, wr_d);
        check("t2_latency", LW'(lat_c), LW'(4));
        check("t2_wr_addr", LW'(wr_a),  LW'(10'h010));
        check("t2_wr_data", wr_d, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        check("t2_rd_addr", LW'(rd_a),  LW'(10'h010));
        check("t2_data",    o_fd[0], 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        check("t2_uninit",  LW'(o_fu[0]), '0);

        // 3: preload top line through a writeback, then read it back
        run_miss(0, 10'h020, 1'b1, 10'h3FF, 128'h1234, lat_c, n_rd, n_wr, rd_a, wr_a, wr_d);
        run_miss(0, 10'h3FF, 1'b0, '0, '0, lat_c, n_rd, n_wr, rd_a, wr_a, wr_d);
        check("t3_fill_addr", LW'(o_fa[0]), LW'(10'h3FF));
        check("t3_data",      o_fd[0], 128'h1234);
        check("t3_writes",    LW'(n_wr), LW'(0));

        // 4: miss_valid held high with a new address every cycle
        @(negedge clock);
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (o_rd[0]) rd_cyc.push_back(i);
            mv[0] = 1'b1; we[0] = 1'b0;
            la[0] = AW'(i * 37 + 1);
        end
        mv[0] = 1'b0;
        check("t4_accepts", LW'(rd_cyc.size() >= 5), LW'(1));
        for (int j = 1; j < rd_cyc.size(); j++) begin
            check("t4_spacing", LW'(rd_cyc[j] - rd_cyc[j-1]), LW'(4));
        end

        // 5: asynchronous reset in the middle of WAIT
        repeat (6) @(negedge clock);
        mv[0] = 1'b1; la[0] = 10'h0AB; we[0] = 1'b0;
        @(negedge clock);
        mv[0] = 1'b0;
        check("t5_read", LW'(o_rd[0]), LW'(1));
        @(negedge clock);
        #1 rst_n[0] = 1'b0;
        #1;
        check("t5_fill_valid", LW'(o_fv[0]), '0);
        check("t5_mem_rw",     LW'({o_rd[0], o_wr[0]}), '0);
        check("t5_fill_addr",  LW'(o_fa[0]), '0);
        check("t5_fill_data",  o_fd[0], '0);
        check("t5_fill_uninit", LW'(o_fu[0]), '0);
        check("t5_mem_addr",   LW'(o_ma[0]), '0);
        repeat (2) @(negedge clock);
        rst_n[0] = 1'b1;
        @(negedge clock);
        check("t5_ready_after", LW'(o_rdy[0]), LW'(1));
        run_miss(0, 10'h3FF, 1'b0, '0, '0, lat_c, n_rd, n_wr, rd_a, wr_a, wr_d);
        check("t5_latency", LW'(lat_c), LW'(3));
        check("t5_data",    o_fd[0], 128'h1234);

        // 6: longer response latency
        run_miss(1, 10'h001, 1'b0, '0, '0, lat_c, n_rd, n_wr, rd_a, wr_a, wr_d);
        check("t6_latency", LW'(lat_c), LW'(5));
        check("t6_rd_addr", LW'(rd_a),  LW'(10'h001));
        check("t6_uninit",  LW'(o_fu[1]), LW'(1));

        // randomized traffic on both instances
        fork
            rand_run(0);
            rand_run(1);
        join
        repeat (12) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
